// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue stage that buffers ALU commands and sequences operand load, wait and result capture
//
// Purpose:
//   Queues {op, a, b} commands in a DEPTH-entry FIFO. It presents each command to the
//   8-bit ALU from registers and waits a per-class latency: LAT for ops 0000-1110 and
//   MUL_LAT for the sequential multiply, op 1111. It then captures the 16-bit result and
//   carry-out and holds them on a valid/ready result port until the consumer takes them.
//   Before every multiply, alu_rst pulses low for one cycle to restart the multiplier.
//
// Optional build macro:
//   ALU_ISSUE_STATS_EN - adds saturating 16-bit pop counters issue_cnt and mul_cnt.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_ready = !full
//   cmd_op, cmd_a, cmd_b          command opcode and operands
//   alu_a, alu_b, alu_op          registered operands/opcode driving the ALU
//   alu_rst                       multiplier restart, active-low, idle high
//   alu_s, alu_cout               ALU result and carry-out
//   res_valid/res_ready           result handshake
//   res_data, res_cout, res_op    captured result, carry-out and originating opcode
//   busy                          high while an op is in flight or the FIFO holds entries
//   issue_cnt, mul_cnt            (ALU_ISSUE_STATS_EN only) pop counters

module alu_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int LAT     = 2,
    parameter int MUL_LAT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_rst,
    input  logic [15:0] alu_s,
    input  logic        alu_cout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_cout,
    output logic [3:0]  res_op,
    output logic        busy
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0] issue_cnt,
    output logic [15:0] mul_cnt
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int MAXL = (MUL_LAT > LAT) ? MUL_LAT : LAT;
    // The counter only ever holds latency-1, so MAXL-1 is its largest value.
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    localparam logic [3:0] OP_MUL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [19:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [3:0]    head_op;
    logic [7:0]    head_a;
    logic [7:0]    head_b;
    logic          head_is_mul;

    // The extra pointer MSB separates "full" (same index, wrapped once more) from "empty".
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // full is the registered state at the start of the cycle. A pop on the same edge
    // does not open a slot for this edge's push.
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    assign {head_op, head_a, head_b} = mem[rd_ptr[AW-1:0]];
    assign head_is_mul = (head_op == OP_MUL);

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          capture;
    logic          release_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE) || !empty;

    // ------------------------------------------------------------------
    // ALU drive: the operands change only on a pop, so they stay put through WAIT/HOLD
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            alu_rst <= 1'b1;
            cnt     <= '0;
        end else begin
            // Low exactly for the cycle after a multiply is loaded; high every other cycle.
            alu_rst <= !(pop && head_is_mul);
            if (pop) begin
                alu_a  <= head_a;
                alu_b  <= head_b;
                alu_op <= head_op;
                cnt    <= head_is_mul ? CW'(MUL_LAT - 1) : CW'(LAT - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Result port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            res_op    <= '0;
        end else begin
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= alu_s;
                res_cout  <= alu_cout;
                // alu_op is still the opcode of the op whose result is being sampled.
                res_op    <= alu_op;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating issue statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
            mul_cnt   <= '0;
        end else if (pop) begin
            if (issue_cnt != 16'hFFFF) begin
                issue_cnt <= issue_cnt + 16'd1;
            end
            if (head_is_mul && (mul_cnt != 16'hFFFF)) begin
                mul_cnt <= mul_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized self-checking bench for alu_issue_ctrl against a transaction-level model
module tb_alu_issue_ctrl;

    localparam int DEPTH   = 4;
    localparam int LAT     = 2;
    localparam int MUL_LAT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic        alu_rst;
    logic [15:0] alu_s;
    logic        alu_cout;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_cout;
    logic [3:0]  res_op;
    logic        busy;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issue_cnt;
    logic [15:0] mul_cnt;
`endif

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(DEPTH), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rst(alu_rst),
        .alu_s(alu_s), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cout(res_cout), .res_op(res_op),
        .busy(busy)
`ifdef ALU_ISSUE_STATS_EN
        , .issue_cnt(issue_cnt), .mul_cnt(mul_cnt)
`endif
    );

    // Stand-in ALU: {cout, S}
    function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  t;
        logic [15:0] p;
        case (op)
            4'h0: begin t = {1'b0, a} + {1'b0, b}; return {t[8], 8'h00, t[7:0]}; end
            4'h1: begin t = {1'b0, a} - {1'b0, b}; return {t[8], 8'h00, t[7:0]}; end
            4'hB: return {1'b0, 8'h00, a & b};
            4'hF: begin p = {8'h00, a} * {8'h00, b}; return {1'b0, p}; end
            default: return {^a, b, a ^ {4'h0, op}};
        endcase
    endfunction

    assign {alu_cout, alu_s} = alu_f(alu_op, alu_a, alu_b);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Transaction model: every accepted, not-yet-handshaken command with its accept edge.
    // The oldest loads one edge after both it was accepted and the previous result left.
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         pe;
    } cmd_t;

    cmd_t        q[$];
    int          last_hs = 0;
    int          accepted = 0;
    int          last_push_edge = 0;
    logic        last_ready = 1'b0;
    int          rise_cnt = 0;
    int          last_rise_edge = 0;
    logic [15:0] last_rise_data = '0;
    logic        last_rise_cout = 1'b0;
    logic [3:0]  last_rise_op = '0;
    logic        prev_valid = 1'b0;
    int          rst_low_cnt = 0;
    int          last_rst_low_edge = 0;
    logic [15:0] rise_q[$];

    task automatic observe();
        int          n;
        int          ld;
        int          rise;
        bit          loaded;
        bit          vexp;
        logic [16:0] e;
        n = q.size();
        ld = 0;
        rise = 0;
        loaded = 1'b0;
        if (n > 0) begin
            ld = ((last_hs > q[0].pe) ? last_hs : q[0].pe) + 1;
            loaded = (cyc >= ld);
            rise = ld + ((q[0].op == 4'hF) ? MUL_LAT : LAT);
        end
        vexp = (n > 0) && (cyc >= rise);
        check("busy", busy, n > 0);
        check("cmd_ready", cmd_ready, (n - int'(loaded)) < DEPTH);
        check("res_valid", res_valid, vexp);
        check("alu_rst", alu_rst, !((n > 0) && (q[0].op == 4'hF) && (cyc == ld)));
        if (vexp) begin
            e = alu_f(q[0].op, q[0].a, q[0].b);
            check("res_data", res_data, e[15:0]);
            check("res_cout", res_cout, e[16]);
            check("res_op", res_op, q[0].op);
        end
        if (loaded) begin
            check("alu_a", alu_a, q[0].a);
            check("alu_b", alu_b, q[0].b);
            check("alu_op", alu_op, q[0].op);
        end
        if (!alu_rst) begin
            rst_low_cnt++;
            last_rst_low_edge = cyc;
        end
        if (res_valid && !prev_valid) begin
            rise_cnt++;
            last_rise_edge = cyc;
            last_rise_data = res_data;
            last_rise_cout = res_cout;
            last_rise_op = res_op;
            rise_q.push_back(res_data);
        end
        prev_valid = res_valid;
    endtask

    // One clock: check state left by the previous edge, then drive inputs for the next edge.
    task automatic cycle(input logic cv, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic rr);
        @(negedge clk);
        observe();
        cmd_valid = cv;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        res_ready = rr;
        last_ready = cmd_ready;
        if (cv && cmd_ready) begin
            q.push_back('{op: op, a: a, b: b, pe: cyc + 1});
            accepted++;
            last_push_edge = cyc + 1;
        end
        if (res_valid && rr && (q.size() > 0)) begin
            void'(q.pop_front());
            last_hs = cyc + 1;
        end
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 8'h00, 8'h00, rr);
    endtask

    task automatic push_one(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int k;
        k = 0;
        do begin
            cycle(1'b1, op, a, b, 1'b1);
            k++;
        end while (!last_ready && k < 100);
        check("push_timeout", last_ready, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 300) begin
            cycle(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
            k++;
        end
        check("drain_timeout", q.size(), 0);
        cycle(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
        check("busy_after_drain", busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        #1;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, 16'h0000);
        check("rst_res_cout", res_cout, 1'b0);
        check("rst_res_op", res_op, 4'h0);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        check("rst_alu_op", alu_op, 4'h0);
        check("rst_alu_rst", alu_rst, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
`ifdef ALU_ISSUE_STATS_EN
        check("rst_issue_cnt", issue_cnt, 16'h0000);
        check("rst_mul_cnt", mul_cnt, 16'h0000);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        last_hs = cyc;
        prev_valid = 1'b0;
    endtask

    initial begin
        int t;
        int a0;
        int r0;
        int lim;

        do_reset();

        // Add: E3 + 7B
        push_one(4'h0, 8'hE3, 8'h7B);
        t = last_push_edge;
        drain();
        check("add_latency", last_rise_edge - t, 3);
        check("add_data", last_rise_data, 16'h005E);
        check("add_cout", last_rise_cout, 1'b1);

        // Multiply: 8E * 12
        a0 = rst_low_cnt;
        push_one(4'hF, 8'h8E, 8'h12);
        t = last_push_edge;
        drain();
        check("mul_latency", last_rise_edge - t, 11);
        check("mul_data", last_rise_data, 16'h09FC);
        check("mul_op", last_rise_op, 4'hF);
        check("mul_rst_cycles", rst_low_cnt - a0, 1);
        check("mul_rst_edge", last_rst_low_edge, t + 1);

        // Backpressure: six back-to-back commands with the consumer stalled
        a0 = accepted;
        r0 = rise_cnt;
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i), 8'($urandom), 8'($urandom), 1'b0);
        check("bp_accepted", accepted - a0, 5);
        check("bp_ready_6th", last_ready, 1'b0);
        idle(6, 1'b0);
        drain();
        check("bp_results", rise_cnt - r0, 5);

        // Wrap-around: twelve ANDs with FF
        rise_q.delete();
        for (int i = 0; i < 12; i++) push_one(4'hB, 8'(i), 8'hFF);
        drain();
        check("wrap_count", rise_q.size(), 12);
        for (int i = 0; i < 12 && i < rise_q.size(); i++) check("wrap_data", rise_q[i], {8'h00, 8'(i)});

        // Reset four cycles after a multiply load, with two commands queued
        push_one(4'hF, 8'h55, 8'h66);
        t = last_push_edge;
        push_one(4'h0, 8'h01, 8'h02);
        push_one(4'h1, 8'h09, 8'h03);
        lim = 0;
        while (cyc < t + 4 && lim < 20) begin
            cycle(1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
            lim++;
        end
        do_reset();
        r0 = rise_cnt;
        idle(20, 1'b1);
        check("post_rst_no_result", rise_cnt - r0, 0);
        push_one(4'h0, 8'h12, 8'h34);
        drain();
        check("post_rst_count", rise_cnt - r0, 1);
        check("post_rst_data", last_rise_data, 16'h0046);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 99) < 60,
                  ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom),
                  8'($urandom), 8'($urandom),
                  $urandom_range(0, 99) < 70);
        end
        drain();

`ifdef ALU_ISSUE_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) push_one(4'h0, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 2; i++) push_one(4'hF, 8'($urandom), 8'($urandom));
        drain();
        check("stats_issue", issue_cnt, 16'd5);
        check("stats_mul", mul_cnt, 16'd2);
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 8-bit ALU. Buffers {op, a, b} commands in a small FIFO and drives the ALU operand/opcode inputs from registers.
- Waits a fixed number of cycles per op class: a short latency for single-cycle ops and a long latency for the sequential multiply (op 4'b1111).
- Captures the 16-bit result and carry-out, then presents them on a valid/ready result port.
- Generates the one-cycle active-low restart pulse the multiplier needs before each multiply.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- LAT, 2, cycles from operand load to result sample for ops 0000–1110; minimum 1.
- MUL_LAT, 10, cycles from operand load to result sample for op 1111; minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  4  ALU opcode.
- cmd_a  in  8  operand a.
- cmd_b  in  8  operand b.
- alu_a  out  8  registered operand to ALU a.
- alu_b  out  8  registered operand to ALU b.
- alu_op  out  4  registered opcode to ALU op.
- alu_rst  out  1  multiplier restart, active-low; idle high.
- alu_s  in  16  ALU result S.
- alu_cout  in  1  ALU carry-out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  16  captured result.
- res_cout  out  1  captured carry-out.
- res_op  out  4  opcode that produced res_data.
- busy  out  1  high whenever state != IDLE or FIFO non-empty.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, pointers 0; state IDLE.
  - alu_a, alu_b, alu_op = 0; alu_rst = 1.
  - res_valid = 0; res_data = 0; res_cout = 0; res_op = 0; busy = 0.
- FIFO push: on edge with cmd_valid && cmd_ready. cmd_ready is computed from full at the start of the cycle. A pop in the same cycle does not free a slot for that cycle's push.
- Pointers are log2(DEPTH)+1 bits and wrap; full/empty are decided by the MSB compare.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, FIFO non-empty at edge:
    - Pop the head entry; load alu_a/alu_b/alu_op.
    - Load cnt = (op==1111 ? MUL_LAT : LAT) - 1; go to WAIT.
    - If op==1111, alu_rst is driven 0 for exactly this next cycle, then returns to 1.
  - WAIT:
    - cnt != 0: decrement cnt.
    - cnt == 0: capture alu_s, alu_cout, alu_op into res_*; set res_valid = 1; go to HOLD.
  - HOLD:
    - res_valid stays 1; res_* stay stable until res_ready is sampled high.
    - Then res_valid = 0; go to IDLE.
- Latency: command accepted at edge t into an empty FIFO:
  - alu_* update at edge t+1.
  - Result captured and res_valid rises at edge t+1+LAT (or t+1+MUL_LAT).
- alu_a/alu_b/alu_op hold their last values outside LOAD. They do not change during WAIT or HOLD.
- Throughput: one op per (latency + 2) cycles at best, with res_ready tied high.
- Unknown opcodes do not exist: all 16 codes are valid. Only 1111 selects MUL_LAT.
- Reset mid-operation: in-flight op and FIFO contents are discarded. No partial result is emitted. alu_rst returns to 1 immediately.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined: adds output ports issue_cnt (16) and mul_cnt (16).
  - issue_cnt increments on every pop; mul_cnt increments on every op-1111 pop.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Add: op 0000, a=E3, b=7B, bench ALU model, res_ready=1. Required: res_data=005E, res_cout=1, res_valid rises at edge t+3.
- Multiply: op 1111, a=8E, b=12. Required: alu_rst low exactly one cycle after the load edge; res_data=09FC at edge t+11; res_op=1111.
- Backpressure: res_ready=0, push 6 commands back-to-back (DEPTH=4). Required: first 5 accepted (1 in flight + 4 buffered); cmd_ready=0 on the 6th; res_data stable; after res_ready=1, results come out in order with none lost.
- Wrap-around: 12 sequential ops (op 1011, a=i, b=FF). Required: res_data = 00_i for every i in order; pointers wrap correctly; busy=0 after the last handshake.
- Reset mid-multiply: assert rst 4 cycles after a multiply load with 2 queued commands. Required: outputs at reset values immediately; no res_valid after release; the next new command completes normally.
- Stats (macro defined): 3 adds + 2 multiplies. Required: issue_cnt=5, mul_cnt=2; both 0 after rst.
